display_relogio: RTL

Time-multiplexed 6-digit 7-segment driver for the clock (relogio) datapath. It is the consumer end of the counter chain. Each display frame it snapshots the binary hour, minute and second values from the hour/minute/second counters. It splits each value into tens and units, then scans the digits one at a time with a blanking dead-time between them. It sits between the counter chain and the board's common-anode display pins.

---
 rtl/relogio_pkg.sv | 28 ++
 rtl/display_relogio_bcd_7seg.sv | 33 +++
 rtl/display_relogio.sv | 126 ++++++++++++
 3 files changed

// File: rtl/relogio_pkg.sv
// Shared constants for the clock (relogio) display path: active-low
// 7-segment codes, scan digit indices and field range limits.
package relogio_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [2:0] DIG_SU = 3'd0;
    localparam logic [2:0] DIG_ST = 3'd1;
    localparam logic [2:0] DIG_MU = 3'd2;
    localparam logic [2:0] DIG_MT = 3'd3;
    localparam logic [2:0] DIG_HU = 3'd4;
    localparam logic [2:0] DIG_HT = 3'd5;

    localparam logic [4:0] MAX_H  = 5'd23;
    localparam logic [5:0] MAX_MS = 6'd59;

endpackage

// File: rtl/display_relogio_bcd_7seg.sv
// Combinational decimal digit to active-low 7-segment code {g,f,e,d,c,b,a}.
// The dash flag overrides the digit; codes 10..15 show nothing.
module bcd_7seg
    import relogio_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    // Segment lookup with dash override
    always_comb begin
        o_seg = SEG_OFF;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/display_relogio.sv
// Six-digit multiplexed common-anode driver for hh.mm.ss. A frame-wide
// snapshot avoids tearing; every slot opens with DEAD blank cycles so the
// anode never switches while segments still hold the previous digit.
// Outputs are registered from next-state values, so they track the
// scan state with no extra lag.
module display_relogio
    import relogio_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [4:0] hora_i,
    input  logic [5:0] minutos_i,
    input  logic [5:0] segundos_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [16:0]   r_snap;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [16:0]   w_snap_nxt;
    logic          w_slot_end;
    logic [4:0]    w_h;
    logic [5:0]    w_m;
    logic [5:0]    w_s;
    logic [3:0]    w_digit;
    logic          w_dash;
    logic [6:0]    w_seg;
    logic          w_active;
    logic          w_dp_on;

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    // Next scan position and frame snapshot
    always_comb begin
        w_slot_end = (r_cnt == CNT_LAST);
        w_cnt_nxt  = r_cnt + CW'(1);
        w_idx_nxt  = r_idx;
        w_snap_nxt = r_snap;
        if (w_slot_end) begin
            w_cnt_nxt = '0;
            w_idx_nxt = (r_idx == DIG_HT) ? DIG_SU : r_idx + 3'd1;
            if (r_idx == DIG_HT) begin
                w_snap_nxt = {hora_i, minutos_i, segundos_i};
            end
        end
    end

    assign w_h = w_snap_nxt[16:12];
    assign w_m = w_snap_nxt[11:6];
    assign w_s = w_snap_nxt[5:0];

    // Select the digit for the upcoming slot; out-of-range fields show dashes
    always_comb begin
        w_digit = 4'd0;
        w_dash  = 1'b0;
        case (w_idx_nxt)
            DIG_SU: begin w_digit = units(w_s);         w_dash = (w_s > MAX_MS); end
            DIG_ST: begin w_digit = tens(w_s);          w_dash = (w_s > MAX_MS); end
            DIG_MU: begin w_digit = units(w_m);         w_dash = (w_m > MAX_MS); end
            DIG_MT: begin w_digit = tens(w_m);          w_dash = (w_m > MAX_MS); end
            DIG_HU: begin w_digit = units({1'b0, w_h}); w_dash = (w_h > MAX_H);  end
            DIG_HT: begin w_digit = tens({1'b0, w_h});  w_dash = (w_h > MAX_H);  end
            default: begin w_digit = 4'd0;              w_dash = 1'b0;           end
        endcase
    end

    bcd_7seg u_bcd_7seg (
        .i_digit (w_digit),
        .i_dash  (w_dash),
        .o_seg   (w_seg)
    );

    assign w_active = (w_cnt_nxt >= CNT_DEAD);
    assign w_dp_on  = ((w_idx_nxt == DIG_MU) || (w_idx_nxt == DIG_HU)) && !w_s[0];

    // Scan state and registered pin drive; reset blanks the display at once
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt  <= '0;
            r_idx  <= DIG_SU;
            r_snap <= '0;
            r_an   <= 6'b111111;
            r_seg  <= SEG_OFF;
            r_dp   <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_snap <= w_snap_nxt;
            if (w_active) begin
                r_an  <= ~(6'b000001 << w_idx_nxt);
                r_seg <= w_seg;
                r_dp  <= ~w_dp_on;
            end else begin
                r_an  <= 6'b111111;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;
    assign dp_o  = r_dp;

endmodule
